// File: rtl/lcd_bus_monitor.sv
// Responder for the 4-bit HD44780-style LCD write bus: rebuilds bytes from strobes,
// decodes instructions and keeps the visible 2x16 DDRAM image as two packed lines.
module lcd_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_E_HIGH  = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lcd_rs,
  input  logic         lcd_e,
  input  logic         lcd_w,
  input  logic [3:0]   lcd_data,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic         byte_valid,
  output logic [7:0]   byte_out,
  output logic         byte_is_data,
  output logic         four_bit_mode,
  output logic         display_on,
  output logic [6:0]   ddram_addr,
  output logic         e_width_err,
  output logic         proto_err,
  output logic         dbg_phase_low
);

  localparam int CW = $clog2(MIN_E_HIGH + 1) + 1;

  typedef enum logic {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_t;

  // Bus sample packing: {e, rs, w, data[3:0]}
  logic [6:0]    sync_q [SYNC_STAGES];
  logic [6:0]    prev_q;
  logic [CW-1:0] e_cnt;
  logic          strobe;

  phase_t     phase_q, phase_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic       hi_rs_q, hi_rs_d;
  logic [7:0] row0_q [16];
  logic [7:0] row0_d [16];
  logic [7:0] row1_q [16];
  logic [7:0] row1_d [16];
  logic [6:0] ac_q, ac_d;
  logic       inc_q, inc_d, cgram_q, cgram_d, four_q, four_d, disp_q, disp_d;
  logic       bv_q, bv_d, bd_q, bd_d, ee_q, ee_d, pe_q, pe_d;
  logic [7:0] bo_q, bo_d;
  logic       have_byte, new_rs;
  logic [7:0] new_byte;

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a[5:0] >= 6'd39) return {~a[6], 6'd0};
      return a + 7'd1;
    end
    if (a[5:0] == 6'd0) return {~a[6], 6'd39};
    if (a[5:0] > 6'd39) return {a[6], 6'd39};
    return a - 7'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      e_cnt  <= '0;
    end else begin
      sync_q[0] <= {lcd_e, lcd_rs, lcd_w, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!sync_q[SYNC_STAGES-1][6]) e_cnt <= '0;
      else if (e_cnt != '1)          e_cnt <= e_cnt + 1'b1;
    end
  end

  // rs/w/data come from prev_q: the last cycle in which E was still high.
  assign strobe = !sync_q[SYNC_STAGES-1][6] && prev_q[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_HIGH;
      hi_nib_q <= '0;
      hi_rs_q  <= 1'b0;
      for (int c = 0; c < 16; c++) begin
        row0_q[c] <= 8'h20;
        row1_q[c] <= 8'h20;
      end
      ac_q    <= '0;
      inc_q   <= 1'b1;
      cgram_q <= 1'b0;
      four_q  <= 1'b0;
      disp_q  <= 1'b0;
      bv_q    <= 1'b0;
      bo_q    <= '0;
      bd_q    <= 1'b0;
      ee_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      hi_nib_q <= hi_nib_d;
      hi_rs_q  <= hi_rs_d;
      row0_q   <= row0_d;
      row1_q   <= row1_d;
      ac_q     <= ac_d;
      inc_q    <= inc_d;
      cgram_q  <= cgram_d;
      four_q   <= four_d;
      disp_q   <= disp_d;
      bv_q     <= bv_d;
      bo_q     <= bo_d;
      bd_q     <= bd_d;
      ee_q     <= ee_d;
      pe_q     <= pe_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    hi_nib_d  = hi_nib_q;
    hi_rs_d   = hi_rs_q;
    row0_d    = row0_q;
    row1_d    = row1_q;
    ac_d      = ac_q;
    inc_d     = inc_q;
    cgram_d   = cgram_q;
    four_d    = four_q;
    disp_d    = disp_q;
    bv_d      = 1'b0;
    bo_d      = bo_q;
    bd_d      = bd_q;
    ee_d      = ee_q;
    pe_d      = pe_q;
    have_byte = 1'b0;
    new_byte  = '0;
    new_rs    = 1'b0;

    if (strobe) begin
      if (e_cnt < CW'(MIN_E_HIGH)) ee_d = 1'b1;
      if (prev_q[4]) begin
        pe_d = 1'b1;
      end else if (!four_q) begin
        have_byte = 1'b1;
        new_byte  = {prev_q[3:0], 4'h0};
        new_rs    = prev_q[5];
      end else if (phase_q == PH_HIGH) begin
        hi_nib_d = prev_q[3:0];
        hi_rs_d  = prev_q[5];
        phase_d  = PH_LOW;
      end else begin
        have_byte = 1'b1;
        new_byte  = {hi_nib_q, prev_q[3:0]};
        new_rs    = hi_rs_q;
        if (prev_q[5] != hi_rs_q) pe_d = 1'b1;
        phase_d   = PH_HIGH;
      end
    end

    // byte_valid is a one-cycle pulse with no back-pressure; byte_out/byte_is_data hold until the next byte.
    if (have_byte) begin
      bv_d = 1'b1;
      bo_d = new_byte;
      bd_d = new_rs;
      if (!new_rs) begin
        if (new_byte[7]) begin
          ac_d    = new_byte[6:0];
          cgram_d = 1'b0;
        end else if (new_byte[6]) begin
          cgram_d = 1'b1;
        end else if (new_byte[5]) begin
          four_d  = ~new_byte[4];
          phase_d = PH_HIGH;
        end else if (new_byte[4]) begin
        end else if (new_byte[3]) begin
          disp_d = new_byte[2];
        end else if (new_byte[2]) begin
          inc_d = new_byte[1];
        end else if (new_byte[1]) begin
          ac_d = '0;
        end else if (new_byte[0]) begin
          for (int c = 0; c < 16; c++) begin
            row0_d[c] = 8'h20;
            row1_d[c] = 8'h20;
          end
          ac_d  = '0;
          inc_d = 1'b1;
        end
      end else if (!cgram_q) begin
        if (ac_q[5:4] == 2'b00) begin
          if (ac_q[6]) row1_d[ac_q[3:0]] = new_byte;
          else         row0_d[ac_q[3:0]] = new_byte;
        end
        ac_d = ac_step(ac_q, inc_q);
      end
    end
  end

  for (genvar c = 0; c < 16; c++) begin : g_pack
    assign line1[127-8*c -: 8] = row0_q[c];
    assign line2[127-8*c -: 8] = row1_q[c];
  end

  assign byte_valid    = bv_q;
  assign byte_out      = bo_q;
  assign byte_is_data  = bd_q;
  assign four_bit_mode = four_q;
  assign display_on    = disp_q;
  assign ddram_addr    = ac_q;
  assign e_width_err   = ee_q;
  assign proto_err     = pe_q;
  assign dbg_phase_low = (phase_q == PH_LOW);

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: drives bus strobes and checks the rebuilt
// bytes, DDRAM image, address counter, mode bits and error flags.
module tb_lcd_bus_monitor;

  logic         clk, rst_n;
  logic         lcd_rs, lcd_e, lcd_w;
  logic [3:0]   lcd_data;
  logic [127:0] line1, line2;
  logic         byte_valid, byte_is_data, four_bit_mode, display_on;
  logic [7:0]   byte_out;
  logic [6:0]   ddram_addr;
  logic         e_width_err, proto_err, dbg_phase_low;

  int checks = 0;
  int errors = 0;

  logic       last_seen;
  logic [7:0] last_bo;
  int         last_lat;

  localparam logic [127:0] SP = {16{8'h20}};

  lcd_bus_monitor #(.SYNC_STAGES(2), .MIN_E_HIGH(12)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_w(lcd_w),
    .lcd_data(lcd_data), .line1(line1), .line2(line2), .byte_valid(byte_valid),
    .byte_out(byte_out), .byte_is_data(byte_is_data), .four_bit_mode(four_bit_mode),
    .display_on(display_on), .ddram_addr(ddram_addr), .e_width_err(e_width_err),
    .proto_err(proto_err), .dbg_phase_low(dbg_phase_low)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One E strobe held high for hi clock cycles; then watches a bounded window for byte_valid.
  task automatic strobe(input logic rs, input logic w, input logic [3:0] nib, input int hi);
    @(negedge clk);
    lcd_rs = rs; lcd_w = w; lcd_data = nib;
    @(negedge clk);
    lcd_e = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_e = 1'b0;
    last_seen = 1'b0; last_bo = '0; last_lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (byte_valid && !last_seen) begin
        last_seen = 1'b1; last_bo = byte_out; last_lat = i + 1;
      end
    end
  endtask

  task automatic wr4(input logic rs, input logic [7:0] b, input int hi);
    strobe(rs, 1'b0, b[7:4], hi);
    strobe(rs, 1'b0, b[3:0], hi);
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) wr4(1'b1, s[i], 14);
  endtask

  logic [127:0] saved;

  initial begin
    rst_n = 1'b0; lcd_rs = 1'b0; lcd_e = 1'b0; lcd_w = 1'b0; lcd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_line1", line1, SP);
    check("rst_line2", line2, SP);
    check("rst_ac", ddram_addr, 7'h00);
    check("rst_four", four_bit_mode, 1'b0);
    check("rst_disp", display_on, 1'b0);
    check("rst_bv", byte_valid, 1'b0);
    check("rst_bo", byte_out, 8'h00);
    check("rst_errs", {e_width_err, proto_err, byte_is_data}, 3'b000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8-bit init sequence
    strobe(1'b0, 1'b0, 4'h3, 14);
    strobe(1'b0, 1'b0, 4'h3, 14);
    strobe(1'b0, 1'b0, 4'h3, 14);
    check("init_still_8bit", four_bit_mode, 1'b0);
    strobe(1'b0, 1'b0, 4'h2, 14);
    check("init_bv_seen", last_seen, 1'b1);
    check("init_bo", last_bo, 8'h20);
    check("init_latency", last_lat, 3);
    check("init_four", four_bit_mode, 1'b1);
    check("init_phase_high", dbg_phase_low, 1'b0);

    // 4-bit text write
    wr4(1'b0, 8'h0C, 14);
    check("disp_on", display_on, 1'b1);
    wr4(1'b0, 8'h06, 14);
    wr4(1'b0, 8'h80, 14);
    put_str("WELCOME TO CSE  ");
    wr4(1'b0, 8'hC0, 14);
    put_str("I I I  KANPUR   ");
    check("text_line1", line1, 128'h57454C434F4D4520544F204353452020);
    check("text_line2", line2, 128'h492049204920204B414E505552202020);
    check("text_ac", ddram_addr, 7'h50);
    check("text_is_data", byte_is_data, 1'b1);

    // Increment wrap 0x27 -> 0x40
    wr4(1'b0, 8'hA7, 14);
    check("wrap_ac_load", ddram_addr, 7'h27);
    put_str("AB");
    check("wrap_line2", line2, 128'h422049204920204B414E505552202020);
    check("wrap_line1", line1, 128'h57454C434F4D4520544F204353452020);
    check("wrap_ac", ddram_addr, 7'h41);

    // Decrement wrap 0x40 -> 0x27, then clear
    wr4(1'b0, 8'h04, 14);
    wr4(1'b0, 8'hC0, 14);
    put_str("Z");
    check("dec_cell", line2[127:120], 8'h5A);
    check("dec_ac", ddram_addr, 7'h27);
    wr4(1'b0, 8'h01, 14);
    check("clr_line1", line1, SP);
    check("clr_line2", line2, SP);
    check("clr_ac", ddram_addr, 7'h00);

    // Short E pulse: flagged but still accepted (increment restored by clear)
    check("ew_before", e_width_err, 1'b0);
    wr4(1'b1, 8'h51, 5);
    check("ew_flag", e_width_err, 1'b1);
    check("ew_cell", line1[127:120], 8'h51);
    check("ew_ac", ddram_addr, 7'h01);

    // RS mismatch inside a pair: high-nibble RS (instruction) wins
    check("pe_before", proto_err, 1'b0);
    strobe(1'b0, 1'b0, 4'h8, 14);
    strobe(1'b1, 1'b0, 4'h5, 14);
    check("pe_flag", proto_err, 1'b1);
    check("pe_bo", last_bo, 8'h85);
    check("pe_is_instr", byte_is_data, 1'b0);
    check("pe_ac", ddram_addr, 7'h05);

    // Read strobe: ignored
    saved = line1;
    strobe(1'b1, 1'b1, 4'h4, 14);
    check("rd_no_bv", last_seen, 1'b0);
    check("rd_line1", line1, saved);
    check("rd_ac", ddram_addr, 7'h05);
    check("rd_phase", dbg_phase_low, 1'b0);

    // Async reset between nibbles
    strobe(1'b1, 1'b0, 4'h4, 14);
    check("ar_phase_low", dbg_phase_low, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_line1", line1, SP);
    check("ar_four", four_bit_mode, 1'b0);
    check("ar_ac", ddram_addr, 7'h00);
    check("ar_flags", {e_width_err, proto_err, display_on, dbg_phase_low}, 4'b0000);
    check("ar_bo", byte_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    strobe(1'b0, 1'b0, 4'hA, 14);
    check("ar_8bit_seen", last_seen, 1'b1);
    check("ar_8bit_bo", last_bo, 8'hA0);
    check("ar_8bit_ac", ddram_addr, 7'h20);
    strobe(1'b0, 1'b1, 4'h0, 14);
    check("rd_sets_pe", proto_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_monitor.md
Name: lcd_bus_monitor

Overview:
- Responder end of the 4-bit HD44780-style character-LCD write bus (RS, E, W, D[3:0]) produced by the team's lcd_driver.
- Watches the bus, rebuilds bytes from nibble pairs, decodes instructions and keeps a 2x16 DDRAM image.
- Exposes the image as two 128-bit lines in the same packing the driver consumes. Closed-loop benches can then compare the displayed text against the driver's LINE1/LINE2 inputs.
- Synthesisable; also usable as an on-chip bus checker.

Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth on lcd_e, lcd_rs, lcd_w and lcd_data (minimum 1).
- MIN_E_HIGH, 12: minimum number of clk cycles E must stay high. A shorter pulse sets e_width_err.

Ports:
- clk  in  1  system clock; every state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lcd_rs  in  1  register select: 0 = instruction, 1 = data.
- lcd_e  in  1  enable strobe; a transfer is accepted on its falling edge.
- lcd_w  in  1  1 = read cycle, 0 = write cycle.
- lcd_data  in  4  data nibble.
- line1  out  128  visible DDRAM 0x00-0x0F; char 0 in [127:120].
- line2  out  128  visible DDRAM 0x40-0x4F; char 0 in [127:120].
- byte_valid  out  1  one-cycle pulse when a byte has been accepted.
- byte_out  out  8  last accepted byte.
- byte_is_data  out  1  RS value of the last accepted byte.
- four_bit_mode  out  1  interface is currently in 4-bit mode.
- display_on  out  1  D bit from the last display-control instruction.
- ddram_addr  out  7  current address counter (AC).
- e_width_err  out  1  sticky; E high pulse was shorter than MIN_E_HIGH.
- proto_err  out  1  sticky; RS mismatch inside a nibble pair, or a read cycle seen.

Behaviour:
- Reset (asynchronous, rst_n=0) forces all outputs and state to:
  - line1/line2 = all 0x20.
  - AC=0, increment mode, display_on=0, four_bit_mode=0, nibble phase=HIGH.
  - byte_valid=0, byte_out=0, byte_is_data=0, both error flags 0.
  - Synchronizers cleared, E-width counter cleared.
- Reset mid-operation discards any half-received byte.
- Strobe detection:
  - Inputs pass through SYNC_STAGES flops.
  - A falling edge is e_s=0 while the previous e_s=1.
  - rs, w and data are taken from the previous synchronized cycle, i.e. the last cycle in which E was high.
  - A counter of consecutive E-high cycles is compared against MIN_E_HIGH at each falling edge.
  - The transfer is still processed even when the pulse is short.
- Read cycles (w=1) set proto_err and are otherwise ignored. Nibble phase does not change.
- 8-bit mode (after reset): each strobe forms byte = {data, 4'h0}. byte_valid fires on the same strobe.
- 4-bit mode:
  - HIGH phase latches the upper nibble and the RS value.
  - LOW phase forms the byte and pulses byte_valid.
  - If RS differs between the two nibbles, the HIGH-phase RS is used and proto_err is set.
- Latency: byte_valid rises SYNC_STAGES+1 cycles after lcd_e falls at the pin. line outputs, AC and mode bits reflect that byte in the same cycle as byte_valid.
- Instruction decode (RS=0), highest set bit wins:
  - 1xxxxxxx: AC = byte[6:0]; CGRAM select cleared.
  - 01xxxxxx: CGRAM select set; subsequent data writes are dropped with AC unchanged.
  - 001Dxxxx: D=0 sets four_bit_mode; D=1 clears it. The nibble phase returns to HIGH either way.
  - 0001xxxx: shift; no effect.
  - 00001Dxx: display_on=D.
  - 000001Ix: I=1 selects increment, I=0 selects decrement.
  - 0000001x: AC=0.
  - 00000001: all 32 cells = 0x20, AC=0, increment mode; done in one cycle.
  - 00000000: no effect.
- Data write (RS=1, DDRAM selected):
  - The cell at AC is written only if AC is in 0x00-0x0F or 0x40-0x4F.
  - AC then steps by one in the selected direction.
- AC wrap rules:
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x40->0x27, 0x00->0x67.
  - An AC loaded into the hole (0x28-0x3F, 0x68-0x7F) holds that value. A write there is dropped, then AC steps normally, saturating into the valid range: +1 goes to 0x40 or 0x00, -1 goes to 0x27 or 0x67.

Test Plan:
- Init: reset, then 8-bit strobes 0x3, 0x3, 0x3, 0x2 -> four_bit_mode=1 after the 4th byte_valid; byte_out=0x20 on that pulse; nibble phase HIGH.
- 4-bit mode: send 0x80, then data "WELCOME TO CSE" plus two spaces, then 0xC0 and "I I I  KANPUR" padded to 16 chars -> line1=128'h57454C434F4D4520544F204353452020 and line2 matches the padded string.
- Wrap: AC=0x27, write 'A' then 'B' -> 'A' dropped; 'B' lands at line2[127:120]; ddram_addr=0x41.
- Decrement: send 0x04, AC=0x40, write 'Z' -> line2[127:120]=0x5A; ddram_addr=0x27. Then send 0x01 -> both lines all 0x20, AC=0.
- Errors: E high for 5 cycles -> e_width_err=1, byte still accepted. RS=0 on the high nibble and RS=1 on the low nibble -> proto_err=1, byte treated as an instruction. A read strobe leaves the lines unchanged.
- Async reset between nibbles: after a high nibble, pulse rst_n low -> all outputs at reset values immediately; the next strobe is treated as 8-bit mode.
